// File: rtl/spiker_adapter_reg_pkg.sv
// Shared types and sizing for the spike-frame adapter.
// Defaults here size the feeder when it is built with stock parameters.
package spiker_adapter_reg_pkg;

    localparam int unsigned SPK_DATA_WIDTH    = 800;
    localparam int unsigned SPK_N_SPIKES      = 784;
    localparam int unsigned SPK_NIB_WIDTH     = 4;
    localparam int unsigned SPK_SETTLE_CYCLES = 2;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned N_NIBBLES = SPK_N_SPIKES / SPK_NIB_WIDTH;
    localparam int unsigned NIB_CNT_W = cnt_w(N_NIBBLES);
    localparam int unsigned SPK_CNT_W = cnt_w(SPK_N_SPIKES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STREAM,
        ST_DONE
    } spiker_feeder_state_e;

endpackage

// File: rtl/spiker_popcount.sv
// Combinational population count of a W-bit vector.
module spiker_popcount
    import spiker_adapter_reg_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]        bits_i,
    output logic [cnt_w(W)-1:0] cnt_o
);

    localparam int unsigned CW = cnt_w(W);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/spiker_feeder.sv
// Streams a captured spike frame to the core nibble by nibble,
// shifting the upstream reader and tallying nibbles and set spikes.
module spiker_feeder
    import spiker_adapter_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SPK_DATA_WIDTH,
    parameter int unsigned N_SPIKES      = SPK_N_SPIKES,
    parameter int unsigned NIB_WIDTH     = SPK_NIB_WIDTH,
    parameter int unsigned SETTLE_CYCLES = SPK_SETTLE_CYCLES,
    localparam int unsigned NIBS = N_SPIKES / NIB_WIDTH,
    localparam int unsigned NCW  = cnt_w(NIBS),
    localparam int unsigned SCW  = cnt_w(N_SPIKES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  sample_o,
    output logic                  spk_valid_o,
    output logic [NIB_WIDTH-1:0]  spk_data_o,
    output logic                  spk_last_o,
    input  logic                  spk_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NCW-1:0]        nib_cnt_o,
    output logic [SCW-1:0]        spike_cnt_o
);

    localparam int unsigned STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PCW = cnt_w(NIB_WIDTH);

    if (N_SPIKES % NIB_WIDTH != 0) begin : g_bad_nib
        $error("N_SPIKES must be a multiple of NIB_WIDTH");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (N_SPIKES > DATA_WIDTH) begin : g_bad_width
        $error("N_SPIKES must not exceed DATA_WIDTH");
    end

    spiker_feeder_state_e state_q, state_d;
    logic [STW-1:0] settle_q, settle_d;
    logic [NCW-1:0] nib_q, nib_d;
    logic [SCW-1:0] spk_q, spk_d;
    logic [PCW-1:0] pop;
    logic           valid, hs, last;

    spiker_popcount #(
        .W (NIB_WIDTH)
    ) u_pop (
        .bits_i (data_i[NIB_WIDTH-1:0]),
        .cnt_o  (pop)
    );

    assign valid = (state_q == ST_STREAM);
    assign hs    = valid & spk_ready_i;
    assign last  = valid & (nib_q == NCW'(NIBS - 1));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        nib_d    = nib_q;
        spk_d    = spk_q;
        // A handshake always lands, even in the abort cycle.
        if (hs) begin
            nib_d = nib_q + 1'b1;
            spk_d = spk_q + SCW'(pop);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d  = ST_SETTLE;
                    settle_d = STW'(SETTLE_CYCLES - 1);
                    nib_d    = '0;
                    spk_d    = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_STREAM;
                else                settle_d = settle_q - 1'b1;
            end
            ST_STREAM: begin
                if (hs && last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            nib_q    <= '0;
            spk_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            nib_q    <= nib_d;
            spk_q    <= spk_d;
        end
    end

    assign sample_o    = hs;
    assign spk_valid_o = valid;
    assign spk_data_o  = valid ? data_i[NIB_WIDTH-1:0] : '0;
    assign spk_last_o  = last;
    assign busy_o      = (state_q == ST_SETTLE) || (state_q == ST_STREAM);
    assign done_o      = (state_q == ST_DONE);
    assign nib_cnt_o   = nib_q;
    assign spike_cnt_o = spk_q;

    logic unused_ok;
    assign unused_ok = ^{test_mode_i, data_i[DATA_WIDTH-1:NIB_WIDTH]};

endmodule
